// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
// udp_pkg : shared constants and FSM encoding for the UDP receive stage
// Rev 1.0
// ============================================================================
package udp_pkg;

    localparam int         UDP_HDR_LEN   = 8;
    localparam logic [7:0] IP_PROTO_UDP  = 8'h11;

    localparam int         TUSER_MAC_ERR = 0;
    localparam int         TUSER_IP_ERR  = 1;
    localparam int         TUSER_UDP_ERR = 2;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_HDR        = 3'd1;
    localparam logic [2:0] ST_PAYLOAD    = 3'd2;
    localparam logic [2:0] ST_PAD        = 3'd3;
    localparam logic [2:0] ST_DROP       = 3'd4;

endpackage
`default_nettype wire

// File: rtl/udp_rx_csum_acc.sv
`default_nettype none
// ============================================================================
// udp_csum_acc : one's-complement UDP checksum accumulator with two-stage fold
// Rev 1.0
// ============================================================================
module udp_csum_acc (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        add_en,
    input  logic [7:0]  add_byte,
    input  logic        add_hi,
    input  logic        add_dbl,
    output logic        csum_ok
);

    logic [31:0] r_acc;
    logic [31:0] w_term;
    logic [31:0] w_base;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // Bytes are added at their big-endian word weight, so a lone final byte
    // is implicitly padded with 8'h00. add_dbl counts the length field twice
    // (header word plus its pseudo-header copy).
    always_comb begin
        w_term = add_hi ? {16'h0000, add_byte, 8'h00} : {24'h000000, add_byte};
        if (add_dbl) begin
            w_term = w_term << 1;
        end
        if (!add_en) begin
            w_term = 32'h0;
        end
        w_base = load ? seed : r_acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= 32'h0;
        end else if (load || add_en) begin
            r_acc <= w_base + w_term;
        end
    end

    assign w_fold1 = {1'b0, r_acc[31:16]} + {1'b0, r_acc[15:0]};
    assign w_fold2 = w_fold1[15:0] + {15'h0000, w_fold1[16]};
    assign csum_ok = (w_fold2 == 16'hFFFF);

endmodule
`default_nettype wire

// File: rtl/udp_rx.sv
`default_nettype none
// ============================================================================
// udp_rx : UDP header parse/strip, port filter, pad trim and checksum verify
// Rev 1.0
// ============================================================================
module udp_rx
    import udp_pkg::*;
#(
    parameter logic [15:0] LOCAL_PORT     = 16'd8080,
    parameter bit          PORT_FILTER_EN = 1'b1
) (
    input  logic        rx_mac_aclk,
    input  logic        rx_mac_reset,
    input  logic [7:0]  rx_axis_ip_tdata,
    input  logic        rx_axis_ip_tvalid,
    input  logic        rx_axis_ip_tlast,
    input  logic [1:0]  rx_axis_ip_tuser,
    input  logic        rx_axis_ip_tdest,
    input  logic [7:0]  rx_ip_proto,
    input  logic [31:0] rx_ip_src,
    input  logic [31:0] rx_ip_dst,
    output logic [7:0]  rx_axis_udp_tdata,
    output logic        rx_axis_udp_tvalid,
    output logic        rx_axis_udp_tlast,
    output logic [2:0]  rx_axis_udp_tuser,
    output logic [15:0] rx_udp_src_port,
    output logic [15:0] rx_udp_dst_port,
    output logic [15:0] rx_udp_len,
    output logic        rx_udp_hdr_valid
);

    logic [2:0]  r_state, w_next;
    logic [15:0] r_cnt, w_cnt_inc;
    logic [2:0]  w_idx;
    logic [15:0] r_src_port, r_dst_port, r_len;
    logic [7:0]  r_csum_hi;
    logic        r_csum_en;
    logic [7:0]  r_hold;
    logic        r_hold_valid;
    logic        r_fin_pend, r_fin_trunc;
    logic [1:0]  r_fin_user;
    logic        w_beat, w_hdr_byte, w_hdr_done, w_hdr_ok, w_hdr_accept;
    logic        w_pay_byte, w_pay_last, w_truncate;
    logic        w_acc_load, w_acc_add, w_acc_dbl, w_csum_ok;
    logic [31:0] w_seed;

    assign w_seed = {16'h0000, rx_ip_src[31:16]} + {16'h0000, rx_ip_src[15:0]}
                  + {16'h0000, rx_ip_dst[31:16]} + {16'h0000, rx_ip_dst[15:0]}
                  + {24'h000000, rx_ip_proto};

    always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
        if (rx_mac_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_beat) begin
            case (r_state)
                ST_IDLE:    w_next = rx_axis_ip_tdest ? ST_DROP : ST_HDR;
                ST_HDR: begin
                    if (w_hdr_done) begin
                        if (!w_hdr_ok) begin
                            w_next = ST_DROP;
                        end else if (r_len > 16'(UDP_HDR_LEN)) begin
                            w_next = ST_PAYLOAD;
                        end else begin
                            w_next = ST_PAD;
                        end
                    end
                end
                ST_PAYLOAD: if (w_pay_last) w_next = ST_PAD;
                default:    w_next = r_state;
            endcase
            if (rx_axis_ip_tlast) begin
                w_next = ST_IDLE;
            end
        end
    end

    // r_cnt holds the number of datagram bytes consumed before this beat,
    // so it is also the index of the current byte.
    always_comb begin
        w_beat       = rx_axis_ip_tvalid;
        w_idx        = (r_state == ST_IDLE) ? 3'd0 : r_cnt[2:0];
        w_cnt_inc    = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
        w_hdr_byte   = w_beat && (((r_state == ST_IDLE) && !rx_axis_ip_tdest) || (r_state == ST_HDR));
        w_hdr_done   = w_beat && (r_state == ST_HDR) && (r_cnt == 16'(UDP_HDR_LEN - 1));
        w_hdr_ok     = (r_len >= 16'(UDP_HDR_LEN)) && (!PORT_FILTER_EN || (r_dst_port == LOCAL_PORT));
        w_hdr_accept = w_hdr_done && w_hdr_ok;
        w_pay_byte   = w_beat && (r_state == ST_PAYLOAD);
        w_pay_last   = w_pay_byte && (w_cnt_inc == r_len);
        w_truncate   = w_pay_byte && rx_axis_ip_tlast && !w_pay_last;
        w_acc_load   = w_hdr_byte && (r_state == ST_IDLE);
        w_acc_add    = w_hdr_byte || w_pay_byte;
        w_acc_dbl    = (r_state == ST_HDR) && ((r_cnt == 16'd4) || (r_cnt == 16'd5));
    end

    udp_csum_acc u_csum (
        .clk      (rx_mac_aclk),
        .rst      (rx_mac_reset),
        .load     (w_acc_load),
        .seed     (w_seed),
        .add_en   (w_acc_add),
        .add_byte (rx_axis_ip_tdata),
        .add_hi   (~w_idx[0]),
        .add_dbl  (w_acc_dbl),
        .csum_ok  (w_csum_ok)
    );

    always_ff @(posedge rx_mac_aclk or posedge rx_mac_reset) begin
        if (rx_mac_reset) begin
            r_cnt              <= 16'h0;
            r_src_port         <= 16'h0;
            r_dst_port         <= 16'h0;
            r_len              <= 16'h0;
            r_csum_hi          <= 8'h0;
            r_csum_en          <= 1'b0;
            r_hold             <= 8'h0;
            r_hold_valid       <= 1'b0;
            r_fin_pend         <= 1'b0;
            r_fin_trunc        <= 1'b0;
            r_fin_user         <= 2'b00;
            rx_axis_udp_tdata  <= 8'h0;
            rx_axis_udp_tvalid <= 1'b0;
            rx_axis_udp_tlast  <= 1'b0;
            rx_axis_udp_tuser  <= 3'b000;
            rx_udp_src_port    <= 16'h0;
            rx_udp_dst_port    <= 16'h0;
            rx_udp_len         <= 16'h0;
            rx_udp_hdr_valid   <= 1'b0;
        end else begin
            rx_udp_hdr_valid   <= w_hdr_accept;
            rx_axis_udp_tvalid <= 1'b0;
            rx_axis_udp_tlast  <= 1'b0;
            rx_axis_udp_tuser  <= 3'b000;

            if (w_beat) begin
                r_cnt <= (r_state == ST_IDLE) ? 16'd1 : w_cnt_inc;
            end

            if (w_hdr_byte) begin
                case (w_idx)
                    3'd0:    r_src_port[15:8] <= rx_axis_ip_tdata;
                    3'd1:    r_src_port[7:0]  <= rx_axis_ip_tdata;
                    3'd2:    r_dst_port[15:8] <= rx_axis_ip_tdata;
                    3'd3:    r_dst_port[7:0]  <= rx_axis_ip_tdata;
                    3'd4:    r_len[15:8]      <= rx_axis_ip_tdata;
                    3'd5:    r_len[7:0]       <= rx_axis_ip_tdata;
                    3'd6:    r_csum_hi        <= rx_axis_ip_tdata;
                    default: r_csum_en        <= (r_csum_hi != 8'h00) || (rx_axis_ip_tdata != 8'h00);
                endcase
            end

            if (w_hdr_accept) begin
                rx_udp_src_port <= r_src_port;
                rx_udp_dst_port <= r_dst_port;
                rx_udp_len      <= r_len;
            end

            // Final beat is committed purely from registers, so the next
            // frame may already be re-seeding the accumulator this cycle.
            if (r_fin_pend) begin
                rx_axis_udp_tvalid                       <= 1'b1;
                rx_axis_udp_tlast                        <= 1'b1;
                rx_axis_udp_tdata                        <= r_hold;
                rx_axis_udp_tuser[TUSER_UDP_ERR]         <= r_fin_trunc || (r_csum_en && !w_csum_ok);
                rx_axis_udp_tuser[TUSER_IP_ERR:TUSER_MAC_ERR] <= r_fin_user;
                r_fin_pend                               <= 1'b0;
            end

            if (w_pay_byte) begin
                if (r_hold_valid) begin
                    rx_axis_udp_tvalid <= 1'b1;
                    rx_axis_udp_tdata  <= r_hold;
                end
                r_hold       <= rx_axis_ip_tdata;
                r_hold_valid <= 1'b1;
            end

            if (w_beat && rx_axis_ip_tlast) begin
                r_fin_pend   <= r_hold_valid || w_pay_byte;
                r_fin_user   <= rx_axis_ip_tuser;
                r_fin_trunc  <= w_truncate;
                r_hold_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_udp_rx.sv
`timescale 1ns/1ps
`default_nettype none
// tb_udp_rx : directed self-checking bench for udp_rx (filtered and unfiltered instances)
module tb_udp_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tdata = 8'h0;
    logic        tvalid = 1'b0, tlast = 1'b0, tdest = 1'b0;
    logic [1:0]  tuser = 2'b00;
    logic [7:0]  proto = 8'h11;
    logic [31:0] ip_src = 32'hC0A8_0102;
    logic [31:0] ip_dst = 32'hC0A8_0101;

    logic [7:0]  u_data, n_data;
    logic        u_valid, u_last, n_valid, n_last;
    logic [2:0]  u_user, n_user;
    logic [15:0] u_sp, u_dp, u_len, n_sp, n_dp, n_len;
    logic        u_hv, n_hv;

    always #5 clk = ~clk;

    udp_rx #(.LOCAL_PORT(16'd8080), .PORT_FILTER_EN(1'b1)) dut (
        .rx_mac_aclk(clk), .rx_mac_reset(rst),
        .rx_axis_ip_tdata(tdata), .rx_axis_ip_tvalid(tvalid), .rx_axis_ip_tlast(tlast),
        .rx_axis_ip_tuser(tuser), .rx_axis_ip_tdest(tdest),
        .rx_ip_proto(proto), .rx_ip_src(ip_src), .rx_ip_dst(ip_dst),
        .rx_axis_udp_tdata(u_data), .rx_axis_udp_tvalid(u_valid), .rx_axis_udp_tlast(u_last),
        .rx_axis_udp_tuser(u_user), .rx_udp_src_port(u_sp), .rx_udp_dst_port(u_dp),
        .rx_udp_len(u_len), .rx_udp_hdr_valid(u_hv)
    );

    udp_rx #(.LOCAL_PORT(16'd8080), .PORT_FILTER_EN(1'b0)) dut_nf (
        .rx_mac_aclk(clk), .rx_mac_reset(rst),
        .rx_axis_ip_tdata(tdata), .rx_axis_ip_tvalid(tvalid), .rx_axis_ip_tlast(tlast),
        .rx_axis_ip_tuser(tuser), .rx_axis_ip_tdest(tdest),
        .rx_ip_proto(proto), .rx_ip_src(ip_src), .rx_ip_dst(ip_dst),
        .rx_axis_udp_tdata(n_data), .rx_axis_udp_tvalid(n_valid), .rx_axis_udp_tlast(n_last),
        .rx_axis_udp_tuser(n_user), .rx_udp_src_port(n_sp), .rx_udp_dst_port(n_dp),
        .rx_udp_len(n_len), .rx_udp_hdr_valid(n_hv)
    );

    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         hv_cnt = 0, hv_cyc = 0, hdr7_cyc = 0, last_cyc = 0;
    int         ob = 0, nb = 0, hb = 0;
    logic [7:0] oq_data[$];
    logic [2:0] oq_user[$];
    logic       oq_last[$];
    int         oq_cyc[$];
    logic [7:0] nq_data[$];
    logic [2:0] nq_user[$];
    logic [7:0] fq[$];
    logic [7:0] pq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_valid) begin
            oq_data.push_back(u_data);
            oq_user.push_back(u_user);
            oq_last.push_back(u_last);
            oq_cyc.push_back(cyc);
        end
        if (n_valid) begin
            nq_data.push_back(n_data);
            nq_user.push_back(n_user);
        end
        if (u_hv) begin
            hv_cnt = hv_cnt + 1;
            hv_cyc = cyc;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_payload4();
        pq.delete();
        pq.push_back(8'hDE); pq.push_back(8'hAD); pq.push_back(8'hBE); pq.push_back(8'hEF);
    endtask

    task automatic build(input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len,
                         input logic [15:0] ck, input int npad);
        fq.delete();
        fq.push_back(sp[15:8]);  fq.push_back(sp[7:0]);
        fq.push_back(dp[15:8]);  fq.push_back(dp[7:0]);
        fq.push_back(len[15:8]); fq.push_back(len[7:0]);
        fq.push_back(ck[15:8]);  fq.push_back(ck[7:0]);
        foreach (pq[i]) fq.push_back(pq[i]);
        for (int i = 0; i < npad; i++) fq.push_back(8'h77);
    endtask

    task automatic send(input logic dest, input logic [1:0] user, input bit with_last);
        for (int i = 0; i < fq.size(); i++) begin
            @(posedge clk); #1;
            tvalid = 1'b1;
            tdata  = fq[i];
            tdest  = dest;
            tlast  = with_last && (i == fq.size() - 1);
            tuser  = tlast ? user : 2'b00;
            if (i == 7) hdr7_cyc = cyc;
            if (tlast)  last_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        tvalid = 1'b0; tlast = 1'b0; tuser = 2'b00; tdest = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mark();
        ob = oq_data.size();
        nb = nq_data.size();
        hb = hv_cnt;
    endtask

    task automatic check_out(input string tag, input logic [2:0] exp_user);
        int n;
        n = oq_data.size() - ob;
        check_val({tag, "_beats"}, n, pq.size());
        for (int i = 0; i < n && i < pq.size(); i++) begin
            check_val({tag, "_data"}, oq_data[ob+i], pq[i]);
            check_val({tag, "_last"}, oq_last[ob+i], (i == pq.size() - 1));
            check_val({tag, "_user"}, oq_user[ob+i], (i == pq.size() - 1) ? exp_user : 3'b000);
        end
        if (n > 0) check_val({tag, "_lat"}, oq_cyc[ob+n-1] - last_cyc, 2);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_valid", u_valid, 1'b0);
        check_val("rst_last", u_last, 1'b0);
        check_val("rst_user", u_user, 3'b000);
        check_val("rst_len", u_len, 16'h0);
        check_val("rst_hv", u_hv, 1'b0);
        rst = 1'b0;

        // Good datagram, udp_len 12
        set_payload4(); mark();
        build(16'h1234, 16'h1F90, 16'd12, 16'hAD20, 0);
        send(1'b0, 2'b00, 1'b1); idle(5);
        check_out("good", 3'b000);
        check_val("good_hv_cnt", hv_cnt - hb, 1);
        check_val("good_hv_lat", hv_cyc - hdr7_cyc, 1);
        check_val("good_len", u_len, 16'd12);
        check_val("good_dport", u_dp, 16'd8080);
        check_val("good_sport", u_sp, 16'h1234);

        // Corrupted checksum
        mark(); build(16'h1234, 16'h1F90, 16'd12, 16'hAD21, 0);
        send(1'b0, 2'b00, 1'b1); idle(5);
        check_out("badck", 3'b100);

        // Checksum disabled
        mark(); build(16'h1234, 16'h1F90, 16'd12, 16'h0000, 0);
        send(1'b0, 2'b00, 1'b1); idle(5);
        check_out("zerock", 3'b000);

        // Odd single-byte payload with Ethernet padding
        pq.delete(); pq.push_back(8'h5A); mark();
        build(16'h1234, 16'h1F90, 16'd9, 16'hF0C3, 9);
        send(1'b0, 2'b00, 1'b1); idle(5);
        check_out("odd", 3'b000);
        check_val("odd_len", u_len, 16'd9);

        // Port 53: dropped by filtered instance, forwarded by unfiltered one
        set_payload4(); mark();
        build(16'h1234, 16'h0035, 16'd12, 16'hCC7B, 0);
        send(1'b0, 2'b00, 1'b1); idle(5);
        check_val("filt_beats", oq_data.size() - ob, 0);
        check_val("filt_hv", hv_cnt - hb, 0);
        check_val("nf_beats", nq_data.size() - nb, 4);
        for (int i = 0; i < 4 && nb + i < nq_data.size(); i++)
            check_val("nf_data", nq_data[nb+i], pq[i]);
        if (nq_data.size() > nb) check_val("nf_user", nq_user[nq_data.size()-1], 3'b000);

        // ICMP frame then UDP frame back-to-back, MAC error on UDP tlast
        mark();
        fq.delete();
        fq.push_back(8'h08); fq.push_back(8'h00); fq.push_back(8'hF7); fq.push_back(8'hFF);
        fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h00); fq.push_back(8'h00);
        send(1'b1, 2'b00, 1'b1);
        build(16'h1234, 16'h1F90, 16'd12, 16'hAD20, 0);
        send(1'b0, 2'b01, 1'b1); idle(5);
        check_out("icmp_udp", 3'b001);
        check_val("icmp_udp_hv", hv_cnt - hb, 1);

        // Truncated: udp_len 20, only 4 payload bytes
        mark(); build(16'h1234, 16'h1F90, 16'd20, 16'h0000, 0);
        send(1'b0, 2'b00, 1'b1); idle(5);
        check_out("trunc", 3'b100);

        // Reset in the middle of a payload, then a clean frame
        build(16'h1234, 16'h1F90, 16'd12, 16'hAD20, 0);
        void'(fq.pop_back()); void'(fq.pop_back());
        send(1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        tvalid = 1'b0; rst = 1'b1;
        mark();
        @(negedge clk);
        check_val("mid_rst_valid", u_valid, 1'b0);
        check_val("mid_rst_len", u_len, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        build(16'h1234, 16'h1F90, 16'd12, 16'hAD20, 0);
        send(1'b0, 2'b00, 1'b1); idle(5);
        check_out("post_rst", 3'b000);
        check_val("post_rst_len", u_len, 16'd12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
